// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 classic bus bundle between a master and the wb_sram_slave responder.
interface wb_sram_slave_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [DW-1:0]   S_DAT_I;
    logic [AW-1:0]   S_ADR_I;
    logic [DW-1:0]   S_DAT_O;
    logic            S_WE_I;
    logic [DW/8-1:0] S_SEL_I;
    logic            S_STB_I;
    logic            S_CYC_I;
    logic            S_ACK_O;
    logic            S_ERR_O;

    modport master (
        output S_DAT_I, S_ADR_I, S_WE_I, S_SEL_I, S_STB_I, S_CYC_I,
        input  S_DAT_O, S_ACK_O, S_ERR_O
    );

    modport slave (
        input  S_DAT_I, S_ADR_I, S_WE_I, S_SEL_I, S_STB_I, S_CYC_I,
        output S_DAT_O, S_ACK_O, S_ERR_O
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic slave fronting a DEPTH-word register-file scratchpad with
// byte-lane writes, programmable wait states and an error response on decode miss.
module wb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             clk,
    input logic             arst_n,
    wb_sram_slave_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SEL_W = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]            WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic                  r_we;
    logic [SEL_W-1:0]      r_sel;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat_o;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_go;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_go  = bus.S_CYC_I & bus.S_STB_I;
    // BASE is aligned to the window size, so a range check reduces to matching the upper bits.
    assign w_hit = (r_adr[ADDR_WIDTH-1:IDX_W+2] == BASE[ADDR_WIDTH-1:IDX_W+2]) &&
                   (r_adr[1:0] == 2'b00);
    assign w_idx = r_adr[IDX_W+1:2];

    always_comb begin
        w_wdata = r_mem[w_idx];
        for (int unsigned i = 0; i < SEL_W; i++) begin
            if (r_sel[i]) begin
                w_wdata[8*i +: 8] = r_dat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A visible ACK/ERR marks the dead cycle: STB is ignored on that edge.
                    if (w_go && !(r_ack || r_err)) begin
                        r_adr   <= bus.S_ADR_I;
                        r_we    <= bus.S_WE_I;
                        r_sel   <= bus.S_SEL_I;
                        r_dat   <= bus.S_DAT_I;
                        r_cnt   <= WS_LOAD;
                        r_state <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!w_go) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (w_hit) begin
                        r_ack <= 1'b1;
                        if (r_we) begin
                            r_mem[w_idx] <= w_wdata;
                        end else begin
                            r_dat_o <= r_mem[w_idx];
                        end
                    end else begin
                        r_err   <= 1'b1;
                        r_dat_o <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.S_ACK_O = r_ack;
    assign bus.S_ERR_O = r_err;
    assign bus.S_DAT_O = r_dat_o;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: one instance with no wait states, one with three.
module tb_wb_sram_slave;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    wb_sram_slave_if #(.AW(32), .DW(32)) bus0 ();
    wb_sram_slave_if #(.AW(32), .DW(32)) bus3 ();

    wb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(BASE), .WAIT_STATES(0)
    ) u0 (
        .clk(clk), .arst_n(arst_n), .bus(bus0)
    );

    wb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(BASE), .WAIT_STATES(3)
    ) u3 (
        .clk(clk), .arst_n(arst_n), .bus(bus3)
    );

    typedef struct {
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
        int          edge_n;
        int          id;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   edge_n = 0;
    int   passed = 0;
    int   total  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endfunction

    // Monitors: every ACK/ERR pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus0.S_ACK_O || bus0.S_ERR_O) begin
            exp_t e;
            chk("dut0_resp_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk($sformatf("dut0_t%0d_ack", e.id), 32'(bus0.S_ACK_O), 32'(!e.err));
                chk($sformatf("dut0_t%0d_err", e.id), 32'(bus0.S_ERR_O), 32'(e.err));
                chk($sformatf("dut0_t%0d_edge", e.id), edge_n, e.edge_n);
                if (e.chk_dat) chk($sformatf("dut0_t%0d_dat", e.id), bus0.S_DAT_O, e.dat);
            end
        end
    end

    always @(negedge clk) begin
        if (bus3.S_ACK_O || bus3.S_ERR_O) begin
            exp_t e;
            chk("dut3_resp_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk($sformatf("dut3_t%0d_ack", e.id), 32'(bus3.S_ACK_O), 32'(!e.err));
                chk($sformatf("dut3_t%0d_err", e.id), 32'(bus3.S_ERR_O), 32'(e.err));
                chk($sformatf("dut3_t%0d_edge", e.id), edge_n, e.edge_n);
                if (e.chk_dat) chk($sformatf("dut3_t%0d_dat", e.id), bus3.S_DAT_O, e.dat);
            end
        end
    end

    task automatic drive(input int d, input logic act, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        if (d == 0) begin
            bus0.S_CYC_I = act; bus0.S_STB_I = act; bus0.S_WE_I = we;
            bus0.S_ADR_I = adr; bus0.S_SEL_I = sel; bus0.S_DAT_I = dat;
        end else begin
            bus3.S_CYC_I = act; bus3.S_STB_I = act; bus3.S_WE_I = we;
            bus3.S_ADR_I = adr; bus3.S_SEL_I = sel; bus3.S_DAT_I = dat;
        end
    endtask

    // after_ack: request is still held from the previous transfer, so the dead edge comes first.
    task automatic xfer(input int d, input int id, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input logic exp_err,
                        input logic [31:0] exp_dat, input logic after_ack, input logic keep);
        exp_t e;
        int   ws;
        logic seen;
        ws   = (d == 0) ? 0 : 3;
        seen = 1'b0;
        if (!after_ack) @(negedge clk);
        drive(d, 1'b1, we, adr, sel, dat);
        e.err     = exp_err;
        e.chk_dat = exp_err || !we;
        e.dat     = exp_err ? 32'h0 : exp_dat;
        e.edge_n  = edge_n + (after_ack ? 2 : 1) + 1 + ws;
        e.id      = id;
        if (d == 0) q0.push_back(e);
        else        q3.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d == 0 ? (bus0.S_ACK_O || bus0.S_ERR_O) : (bus3.S_ACK_O || bus3.S_ERR_O)) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("dut%0d_t%0d_completed", d, id), 32'(seen), 32'd1);
        if (!keep) drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        arst_n = 1'b1;
        #1 arst_n = 1'b0;
        #20;
        chk("rst_ack0", 32'(bus0.S_ACK_O), 32'd0);
        chk("rst_err0", 32'(bus0.S_ERR_O), 32'd0);
        chk("rst_dat0", bus0.S_DAT_O, 32'h0);
        chk("rst_ack3", 32'(bus3.S_ACK_O), 32'd0);
        chk("rst_dat3", bus3.S_DAT_O, 32'h0);
        @(negedge clk) arst_n = 1'b1;
        @(negedge clk);

        // Zero-wait instance: basic access, byte lanes, decode misses.
        xfer(0, 1,  1'b0, BASE + 32'h0,  4'hF, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0);
        xfer(0, 2,  1'b1, BASE + 32'h8,  4'hF, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 1'b0);
        xfer(0, 3,  1'b1, BASE + 32'h8,  4'h5, 32'h11223344,  1'b0, 32'h0,         1'b0, 1'b0);
        xfer(0, 4,  1'b0, BASE + 32'h8,  4'h0, 32'h0,         1'b0, 32'hDE22BE44,  1'b0, 1'b0);
        xfer(0, 5,  1'b0, BASE + 32'h40, 4'hF, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0);
        xfer(0, 6,  1'b1, BASE + 32'h40, 4'hF, 32'h55555555,  1'b1, 32'h0,         1'b0, 1'b0);
        xfer(0, 7,  1'b0, BASE + 32'h2,  4'hF, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0);
        xfer(0, 8,  1'b1, BASE + 32'h2,  4'hF, 32'hA5A5A5A5,  1'b1, 32'h0,         1'b0, 1'b0);
        xfer(0, 9,  1'b0, BASE + 32'h0,  4'hF, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0);
        xfer(0, 10, 1'b1, BASE + 32'h8,  4'h0, 32'hFFFFFFFF,  1'b0, 32'h0,         1'b0, 1'b0);
        xfer(0, 11, 1'b0, BASE + 32'h8,  4'hF, 32'h0,         1'b0, 32'hDE22BE44,  1'b0, 1'b0);
        xfer(0, 12, 1'b0, BASE - 32'h4,  4'hF, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0);

        // Three-wait instance: latency, back-to-back dead cycle, abort.
        xfer(3, 1, 1'b0, BASE + 32'h4, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1);
        xfer(3, 2, 1'b0, BASE + 32'h4, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
        xfer(3, 3, 1'b1, BASE + 32'hC, 4'hF, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0);
        xfer(3, 4, 1'b0, BASE + 32'hC, 4'hF, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b0);

        @(negedge clk);
        drive(3, 1'b1, 1'b1, BASE + 32'hC, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (8) @(negedge clk);
        xfer(3, 5, 1'b0, BASE + 32'hC, 4'hF, 32'h0, 1'b0, 32'h12345678, 1'b0, 1'b0);

        // Reset while a write sits in WAIT.
        @(negedge clk);
        drive(3, 1'b1, 1'b1, BASE + 32'hC, 4'hF, 32'hA5A5A5A5);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("midrst_ack3", 32'(bus3.S_ACK_O), 32'd0);
        chk("midrst_err3", 32'(bus3.S_ERR_O), 32'd0);
        chk("midrst_dat3", bus3.S_DAT_O, 32'h0);
        chk("midrst_dat0", bus0.S_DAT_O, 32'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        xfer(3, 6, 1'b0, BASE + 32'hC, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        xfer(0, 13, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        repeat (6) @(negedge clk);
        chk("sb0_drained", q0.size(), 32'd0);
        chk("sb3_drained", q3.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Wishbone B4 classic (non-pipelined) responder: the slave end of the bus the CPU-side wb_master drives.
- Fronts a small register-file scratchpad of DEPTH 32-bit words with byte-lane writes, programmable wait states and an error response.
- Attaches to a free slave port of wb_interconnect.
- Serves as an on-chip RAM and as a bus-compliance target for the master.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; must be 32.
- DEPTH, 16, number of words; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to DEPTH*4.
- WAIT_STATES, 0, extra cycles inserted before ACK/ERR; 0..15.

Ports:
- clk  input  1  Clock.
- arst_n  input  1  Reset; asynchronous, active-low.
- S_DAT_I  input  DATA_WIDTH  Write data.
- S_ADR_I  input  ADDR_WIDTH  Byte address.
- S_DAT_O  output  DATA_WIDTH  Read data.
- S_WE_I  input  1  Cycle type: 1 = write, 0 = read.
- S_SEL_I  input  DATA_WIDTH/8  Byte-lane select; bit i selects bits 8i+7:8i.
- S_STB_I  input  1  Strobe.
- S_CYC_I  input  1  Bus cycle valid.
- S_ACK_O  output  1  Normal termination.
- S_ERR_O  output  1  Error termination.

Behaviour:
- Reset (arst_n low, asynchronous):
  - S_ACK_O = 0, S_ERR_O = 0, S_DAT_O = 0.
  - FSM goes to IDLE; wait counter = 0.
  - All memory words = 0.
  - Release is synchronous to clk; the design is intended to follow reset_sync.
- Request: CYC_I & STB_I sampled high at a rising edge while in IDLE.
  - Latch ADR, WE, SEL, DAT on that edge.
- Decode of the latched address:
  - Hit when ADR in [BASE_ADDR, BASE_ADDR + 4*DEPTH) and ADR[1:0] == 0.
  - Word index = ADR[log2(DEPTH)+1:2].
  - Miss (out of range or misaligned) gives an error response.
- FSM states:
  - IDLE -> WAIT when a request is sampled and WAIT_STATES > 0; load counter = WAIT_STATES-1.
  - IDLE -> RESP when a request is sampled and WAIT_STATES == 0.
  - WAIT: decrement the counter each cycle; go to RESP when the counter == 0.
  - WAIT -> IDLE (abort) if CYC_I or STB_I is low at any edge. Nothing is written, nothing is asserted.
  - RESP: exactly one of ACK_O/ERR_O is high for exactly one cycle, then the FSM goes to IDLE unconditionally.
  - IDLE after RESP: STB_I is ignored on the edge that ends RESP. The next request can be sampled at the following edge, giving one mandatory dead cycle between back-to-back transfers.
- Latency: request sampled at edge N; ACK/ERR is high in the cycle after edge N+1+WAIT_STATES.
- Writes (hit):
  - Committed on the edge that enters RESP.
  - Only lanes with SEL=1 are updated; SEL = 4'b0000 still returns ACK and changes nothing.
- Reads (hit):
  - S_DAT_O is registered and loaded on the edge entering RESP with the full word; SEL is ignored for reads.
  - S_DAT_O holds until the next read response.
- Error (miss):
  - ERR_O is asserted, no write occurs, S_DAT_O is loaded with 0.
  - ACK_O and ERR_O are never high together.
- CYC_I dropping during RESP does not cancel ACK/ERR; a write entering RESP is already committed.
- Reset asserted mid-transfer: outputs clear immediately, the in-flight write is discarded, and memory is cleared.
- Outputs are all registered; there is no combinational path from the bus inputs to ACK/ERR/DAT_O.

Test Plan:
- Reset then single read at BASE+0x0 with WAIT_STATES=0 -> ACK high 1 cycle, one cycle after STB sampled; DAT_O=0x00000000; ERR stays 0.
- Write 0xDEADBEEF to BASE+0x8 with SEL=4'hF, then write 0x11223344 with SEL=4'b0101, then read BASE+0x8 -> DAT_O=0xDE22BE44.
- WAIT_STATES=3 read of BASE+0x4 -> ACK high exactly 4 cycles after the sampling edge. Back-to-back request held high -> second ACK no earlier than the cycle after the dead cycle.
- Read/write at BASE+4*DEPTH and at BASE+0x2 -> ERR high 1 cycle, ACK 0, DAT_O=0. A following read of word 0 shows it unchanged.
- WAIT_STATES=3 write of 0xCAFEF00D to BASE+0xC, with STB dropped after 1 wait cycle -> no ACK/ERR; a later read returns the prior value.
- Assert arst_n=0 during WAIT of a write -> ACK/ERR/DAT_O = 0 immediately; after release a read of that word returns 0.
